// File: rtl/aes_cipher_iter_pkg.sv
// aes_cipher_iter_pkg: block width, FSM encoding, S-box lookup and GF(2^8) xtime shared by the cipher.
package aes_cipher_iter_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int NB = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_e;
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[8*b +: 8];
    endfunction
endpackage

// File: rtl/aes_cipher_iter_round.sv
// aes_cipher_iter_round: one combinational AES round; MixColumns is skipped when last_i is set.
module aes_cipher_iter_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [0:AES_BLOCK_W-1] state_i,
    input  logic [0:AES_BLOCK_W-1] rk_i,
    input  logic                   last_i,
    output logic [0:AES_BLOCK_W-1] state_o
);
    logic [7:0] sb [NB*NB];
    logic [7:0] sr [NB*NB];
    logic [7:0] mc [NB*NB];
    always_comb begin
        for (int i = 0; i < NB*NB; i++) sb[i] = sub_byte(state_i[8*i +: 8]);
        // byte 4c+r takes row r from column c+r
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < NB; r++)
                sr[NB*c+r] = sb[NB*((c+r)%NB)+r];
        for (int c = 0; c < NB; c++) begin
            mc[NB*c]   = xtime(sr[NB*c])   ^ xtime(sr[NB*c+1]) ^ sr[NB*c+1] ^ sr[NB*c+2] ^ sr[NB*c+3];
            mc[NB*c+1] = sr[NB*c] ^ xtime(sr[NB*c+1]) ^ xtime(sr[NB*c+2]) ^ sr[NB*c+2] ^ sr[NB*c+3];
            mc[NB*c+2] = sr[NB*c] ^ sr[NB*c+1] ^ xtime(sr[NB*c+2]) ^ xtime(sr[NB*c+3]) ^ sr[NB*c+3];
            mc[NB*c+3] = xtime(sr[NB*c]) ^ sr[NB*c] ^ sr[NB*c+1] ^ sr[NB*c+2] ^ xtime(sr[NB*c+3]);
        end
        for (int i = 0; i < NB*NB; i++) state_o[8*i +: 8] = (last_i ? sr[i] : mc[i]) ^ rk_i[8*i +: 8];
    end
endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryptor, one round per clock over a precomputed key schedule.
// AES_SCHED_LATCH_EN captures the schedule at acceptance so it may change while a block is in flight.
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:AES_BLOCK_W-1]            in_block,
    input  logic [0:AES_BLOCK_W*(nr+1)-1]     schedule,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [0:AES_BLOCK_W-1]            out_block
);
    localparam int SCHED_W = AES_BLOCK_W*(nr+1);
    if (nr != nk + 6) begin : g_cfg_err
        $error("aes_cipher_iter: nr must equal nk+6");
    end
    fsm_e                  fsm_q, fsm_d;
    logic [3:0]            rnd_q, rnd_d;
    logic [0:AES_BLOCK_W-1] state_q, state_d;
    logic [0:AES_BLOCK_W-1] rk, round_out;
    logic [0:SCHED_W-1]    sched;
    logic                  last;
`ifdef AES_SCHED_LATCH_EN
    logic [0:SCHED_W-1] sched_q;
    always_ff @(posedge clk)
        sched_q <= rst ? '0 : (in_valid && in_ready) ? schedule : sched_q;
    assign sched = sched_q;
`else
    assign sched = schedule;
`endif
    assign rk   = sched[AES_BLOCK_W*int'(rnd_q) +: AES_BLOCK_W];
    assign last = (rnd_q == 4'(nr));
    aes_cipher_iter_round u_round (
        .state_i (state_q),
        .rk_i    (rk),
        .last_i  (last),
        .state_o (round_out)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            IDLE: if (in_valid) begin
                state_d = in_block ^ schedule[0:AES_BLOCK_W-1];
                rnd_d   = 4'd1;
                fsm_d   = ROUND;
            end
            ROUND: begin
                state_d = round_out;
                rnd_d   = rnd_q + 4'd1;
                fsm_d   = last ? DONE : ROUND;
            end
            DONE:    fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        out_block = state_q;
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: FIPS-197 vectors and random blocks against a field-arithmetic AES model.
// The rekey scenario runs only when AES_SCHED_LATCH_EN is defined.
module tb_aes_cipher_iter;
    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [0:127] in_block, out_block;
    logic [0:1919] sch_a;
    logic iv14, ir14, ov14, or14;
    logic [0:127] ib14, ob14;
    logic [0:1919] sch_b;
    logic [7:0] sbt [256];
    int checks = 0;
    int passed = 0;
    localparam logic [0:255] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_cipher_iter #(.nk(4), .nr(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .schedule(sch_a[0:1407]), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block));
    aes_cipher_iter #(.nk(8), .nr(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .in_block(ib14),
        .schedule(sch_b), .out_valid(ov14), .out_ready(or14), .out_block(ob14));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [0:1919] s = '0;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) w[i] = key[32*i +: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
            s[32*i +: 32] = w[i];
        end
        return s;
    endfunction

    function automatic logic [0:127] cipher(input logic [0:127] pt, input logic [0:1919] sch, input int nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[8*(4*c+r) +: 8] ^ sch[8*(4*c+r) +: 8];
        for (int k = 1; k <= nr; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = ((k == nr) ? t[r][c] : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                              ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]) ^ sch[128*k + 8*(4*c+r) +: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[8*(4*c+r) +: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic xfer(input logic [0:127] pt, output logic [0:127] ct, output int lat);
        in_block = pt;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 60);
        ct = out_block;
    endtask

    task automatic xfer14(input logic [0:127] pt, output logic [0:127] ct, output int lat);
        ib14 = pt;
        iv14 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            iv14 = 1'b0;
            lat++;
        end while (!ov14 && lat < 60);
        ct = ob14;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        iv14 = 1'b1;
        in_block = PT_B;
        ib14 = PT_B;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_block !== 128'h0) $display("FAIL reset out_block got %h want 0", out_block); else passed++;
        checks++; if (ov14 !== 1'b0 || ob14 !== 128'h0) $display("FAIL reset dut14 out got %b/%h want 0/0", ov14, ob14); else passed++;
        rst = 1'b0;
        in_valid = 1'b0;
        iv14 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        logic [0:127] ct;
        int lat;
        sch_a = expand(KEY_B, 4);
        checks++; if (in_ready !== 1'b1) $display("FAIL fips_b idle in_ready got %b want 1", in_ready); else passed++;
        xfer(PT_B, ct, lat);
        checks++; if (ct !== CT_B) $display("FAIL fips_b ciphertext got %h want %h", ct, CT_B); else passed++;
        checks++; if (lat !== 11) $display("FAIL fips_b latency got %0d want 11", lat); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL fips_b done in_ready got %b want 0", in_ready); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL fips_b after handshake out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_fips_c1();
        logic [0:127] ct;
        int lat;
        sch_a = expand(KEY_C1, 4);
        xfer(PT_C, ct, lat);
        checks++; if (ct !== CT_C1) $display("FAIL fips_c1 ciphertext got %h want %h", ct, CT_C1); else passed++;
        @(negedge clk);
    endtask

    task automatic test_aes256();
        logic [0:127] ct;
        int lat;
        sch_b = expand(KEY_C3, 8);
        xfer14(PT_C, ct, lat);
        checks++; if (ct !== CT_C3) $display("FAIL aes256 ciphertext got %h want %h", ct, CT_C3); else passed++;
        checks++; if (lat !== 15) $display("FAIL aes256 latency got %0d want 15", lat); else passed++;
        @(negedge clk);
        checks++; if (ir14 !== 1'b1 || ov14 !== 1'b0) $display("FAIL aes256 after handshake in_ready/out_valid got %b/%b want 1/0", ir14, ov14); else passed++;
    endtask

    task automatic test_backpressure();
        logic [0:127] pt, pt2, exp, ct;
        int lat;
        sch_a = expand({rnd128(), 128'h0}, 4);
        pt = rnd128();
        exp = cipher(pt, sch_a, 10);
        out_ready = 1'b0;
        xfer(pt, ct, lat);
        checks++; if (ct !== exp) $display("FAIL backpressure ciphertext got %h want %h", ct, exp); else passed++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_block = rnd128();
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL backpressure cycle %0d out_valid got %b want 1", i, out_valid); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL backpressure cycle %0d in_ready got %b want 0", i, in_ready); else passed++;
            checks++; if (out_block !== exp) $display("FAIL backpressure cycle %0d out_block got %h want %h", i, out_block, exp); else passed++;
        end
        pt2 = rnd128();
        in_block = pt2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL backpressure release out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); else passed++;
        xfer(pt2, ct, lat);
        exp = cipher(pt2, sch_a, 10);
        checks++; if (ct !== exp) $display("FAIL back_to_back ciphertext got %h want %h", ct, exp); else passed++;
        checks++; if (lat !== 11) $display("FAIL back_to_back latency got %0d want 11", lat); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [0:127] ct;
        int lat;
        int seen = 0;
        sch_a = expand(KEY_B, 4);
        in_block = PT_B;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_mid out_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_block !== 128'h0) $display("FAIL reset_mid out_block got %h want 0", out_block); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_mid in_ready got %b want 1", in_ready); else passed++;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL reset_mid stray out_valid cycles got %0d want 0", seen); else passed++;
        xfer(PT_B, ct, lat);
        checks++; if (ct !== CT_B) $display("FAIL reset_mid recovery ciphertext got %h want %h", ct, CT_B); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [0:127] pt, ct, exp;
        int lat;
        for (int n = 0; n < 6; n++) begin
            sch_a = expand({rnd128(), 128'h0}, 4);
            pt = rnd128();
            exp = cipher(pt, sch_a, 10);
            xfer(pt, ct, lat);
            checks++; if (ct !== exp || lat !== 11) $display("FAIL random128 #%0d got %h lat %0d want %h lat 11", n, ct, lat, exp); else passed++;
            @(negedge clk);
        end
        for (int n = 0; n < 3; n++) begin
            sch_b = expand({rnd128(), rnd128()}, 8);
            pt = rnd128();
            exp = cipher(pt, sch_b, 14);
            xfer14(pt, ct, lat);
            checks++; if (ct !== exp || lat !== 15) $display("FAIL random256 #%0d got %h lat %0d want %h lat 15", n, ct, lat, exp); else passed++;
            @(negedge clk);
        end
    endtask

`ifdef AES_SCHED_LATCH_EN
    task automatic test_rekey();
        int lat = 1;
        sch_a = expand(KEY_B, 4);
        in_block = PT_B;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sch_a = expand(256'h0, 4);
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (out_block !== CT_B) $display("FAIL rekey ciphertext got %h want %h", out_block, CT_B); else passed++;
        checks++; if (lat !== 11) $display("FAIL rekey latency got %0d want 11", lat); else passed++;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv = 8'h00;
            if (i != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(i));
            end
            sbt[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        iv14 = 1'b0;
        out_ready = 1'b1;
        or14 = 1'b1;
        in_block = '0;
        ib14 = '0;
        sch_a = '0;
        sch_b = '0;
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_aes256();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef AES_SCHED_LATCH_EN
        test_rekey();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
